// File: rtl/seg7_pkg.sv
// Segment patterns for the BCD scanner, in active-high form {g,f,e,d,c,b,a}.
// Board polarity is applied by the consumer through apply_polarity().
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  function automatic seg_t apply_polarity(input seg_t s, input bit active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Datapath-facing bundle of the BCD scanner: digit input side and 7-seg pin side.
// load is a one-cycle strobe with no backpressure; the scanner accepts it every cycle.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SW = $clog2(NUM_DIGITS);

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [SW-1:0]           digit_sel;
  logic                    frame_done;

  modport master (
    output en, load, digits,
    input  an, seg, digit_sel, frame_done
  );

  modport slave (
    input  en, load, digits,
    output an, seg, digit_sel, frame_done
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-high 7-segment pattern; 10..15 show a dash.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// N-digit time-multiplexed BCD scanner with double-buffered digits and registered pin drive.
// Optional LEADING_ZERO_BLANK_EN: blank anodes above the most significant nonzero digit.
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input logic               clk,
  input logic               reset,
  bcd_scan_display_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam bit AL = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] IDX_LAST   = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AL ? '1 : '0;

  logic [PW-1:0]           presc;
  logic [SW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] display;
  logic [NUM_DIGITS-1:0]   an_q;
  seg_t                    seg_q;
  logic [SW-1:0]           sel_q;
  logic                    frame_done_q;

  logic                    slot_end;
  logic                    boundary;
  logic                    blank;
  logic                    lz_show;
  logic                    drive;
  logic [3:0]              cur_digit;
  seg_t                    dec_seg;
  logic [NUM_DIGITS-1:0]   onehot;

  assign slot_end  = bus.en && (presc == PRESC_LAST);
  assign boundary  = slot_end && (idx == IDX_LAST);
  assign blank     = int'(presc) < BLANK_CYCLES;
  assign cur_digit = display[{idx, 2'b00} +: 4];
  assign onehot    = NUM_DIGITS'(1) << idx;

`ifdef LEADING_ZERO_BLANK_EN
  logic [SW-1:0] msd;

  // Digit 0 is always shown, so the search starts at digit 1.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display[4*i +: 4] != 4'd0) msd = SW'(i);
    end
  end

  assign lz_show = (idx <= msd);
`else
  assign lz_show = 1'b1;
`endif

  assign drive = bus.en && !blank && lz_show;

  seg7_decoder u_decoder (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      idx          <= '0;
      pending      <= '0;
      display      <= '0;
      an_q         <= AN_OFF;
      seg_q        <= apply_polarity(SEG_OFF, AL);
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.load) pending <= bus.digits;

      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (bus.en) begin
        presc <= presc + 1'b1;
      end

      // Display only changes between frames; a load on the boundary goes straight through.
      if (boundary) display <= bus.load ? bus.digits : pending;

      frame_done_q <= boundary;
      sel_q        <= idx;
      seg_q        <= apply_polarity(dec_seg, AL);
      an_q         <= drive ? (AL ? ~onehot : onehot) : AN_OFF;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized bench for bcd_scan_display against a frame-tick reference model.
// Two instances share stimulus: BLANK_CYCLES=0 and BLANK_CYCLES=1.
module tb_bcd_scan_display;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;
  localparam int W     = 18;

  logic clk;
  logic reset;
  logic en;
  logic load;
  logic [15:0] digits;

  bcd_scan_display_if #(.NUM_DIGITS(ND)) bus0 ();
  bcd_scan_display_if #(.NUM_DIGITS(ND)) bus1 ();

  assign bus0.en = en;
  assign bus0.load = load;
  assign bus0.digits = digits;
  assign bus1.en = en;
  assign bus1.load = load;
  assign bus1.digits = digits;

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(0), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: position within the frame as one tick count
  int          tick;
  logic [15:0] disp_m;
  logic [15:0] pend_m;
  logic [6:0]  seg_tab [16];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nib(input logic [15:0] v, input int i);
    return int'((v >> (4 * i)) & 16'hF);
  endfunction

  function automatic logic [3:0] model_an(input int blank);
    int  slot;
    int  msd;
    bit  show;
    slot = tick / RD;
    show = en && ((tick % RD) >= blank);
`ifdef LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < ND; i++) if (nib(disp_m, i) != 0) msd = i;
    show = show && (slot <= msd);
`else
    msd = ND - 1;
`endif
    return show ? ~(4'b0001 << slot) : 4'hF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(bus0.an), 32'hF);
    check({tag, "_an_b"}, 32'(bus1.an), 32'hF);
    check({tag, "_seg"}, 32'(bus0.seg), 32'h7F);
    check({tag, "_sel"}, 32'(bus0.digit_sel), 32'h0);
    check({tag, "_fd"}, 32'(bus0.frame_done), 32'h0);
  endtask

  task automatic model_reset();
    tick   = 0;
    disp_m = 16'h0;
    pend_m = 16'h0;
    exp_q.delete();
  endtask

  // driver: one clock with current inputs, then compare against the queued prediction
  task automatic step();
    logic [W-1:0] e;
    logic [15:0]  pend_old;
    logic [6:0]   s;
    s = ~seg_tab[nib(disp_m, tick / RD)];
    exp_q.push_back({model_an(0), model_an(1), s, 2'(tick / RD), 1'(en && tick == FRAME - 1)});
    pend_old = pend_m;
    if (load) pend_m = digits;
    if (en) begin
      if (tick == FRAME - 1) disp_m = load ? digits : pend_old;
      tick = (tick + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("an", 32'(bus0.an), 32'(e[17:14]));
    check("an_blank", 32'(bus1.an), 32'(e[13:10]));
    check("seg", 32'(bus0.seg), 32'(e[9:3]));
    check("seg_blank", 32'(bus1.seg), 32'(e[9:3]));
    check("digit_sel", 32'(bus0.digit_sel), 32'(e[2:1]));
    check("frame_done", 32'(bus0.frame_done), 32'(e[0]));
    check("frame_done_b", 32'(bus1.frame_done), 32'(e[0]));
  endtask

  task automatic load_once(input logic [15:0] d);
    digits = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_tick(input int target);
    int n;
    n = 0;
    while (tick != target && n < 4 * FRAME) begin
      step();
      n++;
    end
    if (tick != target) begin
      n_errors++;
      $display("FAIL wait_tick: got %0d expected %0d", tick, target);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

    reset  = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    digits = 16'h0;
    model_reset();
    #1;
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    reset = 1'b0;

    // 1: load 1234 on the first enabled cycle, two full frames
    en = 1'b1;
    load_once(16'h1234);
    run(2 * FRAME + 2);

    // 2: mid-frame load must not tear the current frame
    run_to_tick(2 * RD);
    load_once(16'h5678);
    run(2 * FRAME);

    // 3: dashes and leading zeros, then all-zero
    load_once(16'h00AF);
    run(2 * FRAME);
    load_once(16'h0000);
    run(2 * FRAME);
    load_once(16'h9060);
    run(2 * FRAME);

    // 4: pause the scan at idx=1, presc=2
    run_to_tick(RD + 2);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(FRAME + 3);

    // boundary-coincident load goes straight to display
    run_to_tick(FRAME - 1);
    load_once(16'h4321);
    run(FRAME);

    // 6: async reset at idx=3 with a pending load
    run_to_tick(3 * RD);
    load_once(16'h8888);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_held");
    reset = 1'b0;
    run(2 * FRAME);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 7) == 0);
      digits = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step();
    end
    load = 1'b0;
    en   = 1'b1;
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
